// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pipe
//  Purpose  : Pipelined barrel shifter for the integer ALU. It handles
//             SLL/SRL/SRA and the rotates ROL/ROR, in XLEN-bit or 32-bit
//             (W) form. The shift amount is split across STAGES register
//             stages, starting from its least significant bits.
//  Revision : 1.0 - initial pipelined release
// ============================================================================
module shift_pipe #(
   parameter int XLEN   = 64,
   parameter int STAGES = 2,
   parameter bit ROT_EN = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_ena,
   input  logic [2:0]              i_mode,
   input  logic                    i_word,
   input  logic [XLEN-1:0]         i_a1,
   input  logic [$clog2(XLEN)-1:0] i_a2,
   input  logic                    i_flush,
   output logic                    o_valid,
   output logic [XLEN-1:0]         o_res
);

   localparam int              c_aw       = $clog2(XLEN);
   localparam int              c_chunk    = (c_aw + STAGES - 1) / STAGES;
   localparam int              c_nctl     = (STAGES > 1) ? STAGES - 1 : 1;
   localparam logic [2:0]      c_sll      = 3'b000;
   localparam logic [2:0]      c_srl      = 3'b001;
   localparam logic [2:0]      c_sra      = 3'b010;
   localparam logic [2:0]      c_rol      = 3'b011;
   localparam logic [2:0]      c_ror      = 3'b100;
   localparam logic [c_aw-1:0] c_word_amt = c_aw'(31);
   localparam logic [c_aw:0]   c_xlen     = (c_aw + 1)'(XLEN);

   // Amount bits handled by stage k; stages past the top bit get an empty mask.
   function automatic logic [c_aw-1:0] chunk_mask(input int k);
      logic [c_aw-1:0] m;
      m = '0;
      for (int b = 0; b < c_aw; b++) begin
         if (b >= k * c_chunk && b < (k + 1) * c_chunk) m[b] = 1'b1;
      end
      return m;
   endfunction

   // One partial shift. W results stay zero-extended in the low 32 bits until the end.
   function automatic logic [XLEN-1:0] shift_step(
      input logic [XLEN-1:0] v,
      input logic [2:0]      mode,
      input logic            word,
      input logic [c_aw-1:0] amt
   );
      logic [XLEN-1:0] r;
      logic [31:0]     w;
      logic [31:0]     wr;
      logic [4:0]      wa;
      logic [5:0]      winv;
      logic [c_aw:0]   inv;
      w    = v[31:0];
      wa   = amt[4:0];
      winv = 6'd32 - {1'b0, wa};
      inv  = c_xlen - {1'b0, amt};
      r    = '0;
      wr   = '0;
      if (word) begin
         case (mode)
            c_sll:   wr = w << wa;
            c_srl:   wr = w >> wa;
            c_sra:   wr = $signed(w) >>> wa;
            c_rol:   wr = (w << wa) | (w >> winv);
            c_ror:   wr = (w >> wa) | (w << winv);
            default: wr = '0;
         endcase
         r[31:0] = wr;
      end else begin
         case (mode)
            c_sll:   r = v << amt;
            c_srl:   r = v >> amt;
            c_sra:   r = $signed(v) >>> amt;
            c_rol:   r = (v << amt) | (v >> inv);
            c_ror:   r = (v >> amt) | (v << inv);
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // Copy bit 31 across the upper half of a finished W result.
   function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = v;
      for (int i = 32; i < XLEN; i++) r[i] = v[31];
      return r;
   endfunction

   logic [2:0]      w_mode0;
   logic            w_word0;
   logic [c_aw-1:0] w_amt0;

   logic [XLEN-1:0] r_data [STAGES];
   logic            r_vld  [STAGES];
   logic [2:0]      r_mode [c_nctl];
   logic            r_word [c_nctl];
   logic [c_aw-1:0] r_amt  [c_nctl];

   // Normalise the incoming op: drop W on RV32, fold rotates when disabled, mask W amounts.
   always_comb begin
      w_word0 = (XLEN > 32) ? i_word : 1'b0;
      w_mode0 = i_mode;
      if (!ROT_EN) begin
         if (i_mode == c_rol)      w_mode0 = c_sll;
         else if (i_mode == c_ror) w_mode0 = c_srl;
      end
      w_amt0 = w_word0 ? (i_a2 & c_word_amt) : i_a2;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [c_aw-1:0] c_mask = chunk_mask(k);

      logic [XLEN-1:0] w_din;
      logic [2:0]      w_mode;
      logic            w_word;
      logic [c_aw-1:0] w_amt;
      logic            w_vin;
      logic [XLEN-1:0] w_dout;

      if (k == 0) begin : g_head
         assign w_din  = i_a1;
         assign w_mode = w_mode0;
         assign w_word = w_word0;
         assign w_amt  = w_amt0;
         assign w_vin  = i_ena;
      end else begin : g_body
         assign w_din  = r_data[k-1];
         assign w_mode = r_mode[k-1];
         assign w_word = r_word[k-1];
         assign w_amt  = r_amt[k-1];
         assign w_vin  = r_vld[k-1];
      end

      // Apply this stage's slice of the amount; the last stage also widens W results.
      always_comb begin
         w_dout = shift_step(w_din, w_mode, w_word, w_amt & c_mask);
         if (k == STAGES - 1 && w_word) w_dout = sext_word(w_dout);
      end

      // Valid and data register; a flush kills the op arriving at this edge as well.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_vld[k]  <= 1'b0;
            r_data[k] <= '0;
         end else begin
            r_vld[k] <= w_vin & ~i_flush;
            if (w_vin && !i_flush) r_data[k] <= w_dout;
         end
      end

      if (k < STAGES - 1) begin : g_ctl
         // Carry the op's mode, W flag and the amount bits still to be applied.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_mode[k] <= '0;
               r_word[k] <= 1'b0;
               r_amt[k]  <= '0;
            end else if (w_vin && !i_flush) begin
               r_mode[k] <= w_mode;
               r_word[k] <= w_word;
               r_amt[k]  <= w_amt & ~c_mask;
            end
         end
      end
   end

   assign o_valid = r_vld[STAGES-1];
   assign o_res   = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_pipe
//  Purpose  : Self-checking bench for shift_pipe. Three instances share the
//             same stimulus: (STAGES=2, ROT_EN=1), (STAGES=3, ROT_EN=1) and
//             (STAGES=2, ROT_EN=0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        ena   = 1'b0;
   logic [2:0]  mode  = '0;
   logic        word  = 1'b0;
   logic [63:0] a1    = '0;
   logic [5:0]  a2    = '0;
   logic        flush = 1'b0;

   logic        v0, v1, v2;
   logic [63:0] r0, r1, r2;
   logic        ov   [3];
   logic [63:0] ores [3];

   int checks = 0;
   int errors = 0;

   int          stg [3] = '{2, 3, 2};
   bit          rot [3] = '{1'b1, 1'b1, 1'b0};
   logic [63:0] last_res [3];

   typedef struct {
      int          due;
      logic [63:0] res;
   } ent_t;
   ent_t sb [3][$];

   // Directed vectors and their expected results (rotates enabled / disabled).
   logic [2:0]  d_mode [10] = '{3'd0, 3'd2, 3'd1, 3'd2, 3'd0, 3'd4, 3'd3, 3'd5, 3'd3, 3'd4};
   logic        d_word [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [63:0] d_a1   [10] = '{64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'h1, 64'h1, 64'h8000_0001,
                                64'h1234, 64'hDEAD_BEEF_0123_4567, 64'h1234_5678_9ABC_DEF0};
   logic [5:0]  d_a2   [10] = '{6'd63, 6'd4, 6'd4, 6'd36, 6'd31, 6'd1, 6'd1, 6'd3, 6'd0, 6'd0};
   logic [63:0] d_exp_r [10] = '{64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000,
                                 64'h0800_0000_0000_0000, 64'hFFFF_FFFF_F800_0000,
                                 64'hFFFF_FFFF_8000_0000, 64'h8000_0000_0000_0000, 64'h3,
                                 64'h0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_9ABC_DEF0};
   logic [63:0] d_exp_n [10] = '{64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000,
                                 64'h0800_0000_0000_0000, 64'hFFFF_FFFF_F800_0000,
                                 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h2,
                                 64'h0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_9ABC_DEF0};

   always #5 clk = ~clk;

   shift_pipe #(.XLEN(64), .STAGES(2), .ROT_EN(1'b1)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_word(word),
      .i_a1(a1), .i_a2(a2), .i_flush(flush), .o_valid(v0), .o_res(r0));

   shift_pipe #(.XLEN(64), .STAGES(3), .ROT_EN(1'b1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_word(word),
      .i_a1(a1), .i_a2(a2), .i_flush(flush), .o_valid(v1), .o_res(r1));

   shift_pipe #(.XLEN(64), .STAGES(2), .ROT_EN(1'b0)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_word(word),
      .i_a1(a1), .i_a2(a2), .i_flush(flush), .o_valid(v2), .o_res(r2));

   always_comb begin
      ov[0] = v0;  ov[1] = v1;  ov[2] = v2;
      ores[0] = r0; ores[1] = r1; ores[2] = r2;
   end

   // Bit-by-bit reference: each result bit is picked from the operand by position.
   function automatic logic [63:0] ref_shift(input logic [2:0] m_in, input logic wd,
                                             input logic [63:0] x_in, input logic [5:0] amt,
                                             input bit rt);
      logic [2:0]  m;
      logic [63:0] x;
      logic [63:0] r;
      int          n;
      int          w;
      m = m_in;
      if (!rt && m == 3'd3) m = 3'd0;
      if (!rt && m == 3'd4) m = 3'd1;
      if (m > 3'd4) return 64'd0;
      w = wd ? 32 : 64;
      n = wd ? int'(amt) % 32 : int'(amt);
      x = wd ? {32'd0, x_in[31:0]} : x_in;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (m)
            3'd0: if (i >= n) r[i] = x[i-n];
            3'd1: if (i + n < w) r[i] = x[i+n];
            3'd2: r[i] = (i + n < w) ? x[i+n] : x[w-1];
            3'd3: r[i] = x[(i - n + w) % w];
            default: r[i] = x[(i + n) % w];
         endcase
      end
      if (wd) for (int i = 32; i < 64; i++) r[i] = r[31];
      return r;
   endfunction

   task automatic drive(input logic e, input logic f, input logic [2:0] m, input logic w,
                        input logic [63:0] x, input logic [5:0] s);
      ena = e; flush = f; mode = m; word = w; a1 = x; a2 = s;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || ores[k] !== 64'd0) begin
            errors++;
            $display("FAIL reset_async inst%0d: valid=%b res=%h, expected valid=0 res=0", k, ov[k], ores[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || ores[k] !== 64'd0) begin
            errors++;
            $display("FAIL reset_release inst%0d: valid=%b res=%h, expected valid=0 res=0", k, ov[k], ores[k]);
         end
         last_res[k] = 64'd0;
      end
   endtask

   task automatic test_directed();
      logic [63:0] e;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, d_mode[i], d_word[i], d_a1[i], d_a2[i]);
         @(negedge clk);
         drive(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 6'd0);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (stg[k] == 2) begin
               e = rot[k] ? d_exp_r[i] : d_exp_n[i];
               if (ov[k] !== 1'b1 || ores[k] !== e) begin
                  errors++;
                  $display("FAIL directed[%0d] inst%0d: valid=%b res=%h, expected valid=1 res=%h", i, k, ov[k], ores[k], e);
               end
               last_res[k] = e;
            end else if (ov[k] !== 1'b0 || ores[k] !== last_res[k]) begin
               errors++;
               $display("FAIL directed_early[%0d] inst%0d: valid=%b res=%h, expected valid=0 res=%h", i, k, ov[k], ores[k], last_res[k]);
            end
         end
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (stg[k] == 3) begin
               e = d_exp_r[i];
               if (ov[k] !== 1'b1 || ores[k] !== e) begin
                  errors++;
                  $display("FAIL directed3[%0d] inst%0d: valid=%b res=%h, expected valid=1 res=%h", i, k, ov[k], ores[k], e);
               end
               last_res[k] = e;
            end else if (ov[k] !== 1'b0 || ores[k] !== last_res[k]) begin
               errors++;
               $display("FAIL directed_hold[%0d] inst%0d: valid=%b res=%h, expected valid=0 res=%h", i, k, ov[k], ores[k], last_res[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  om [4];
      logic        ow [4];
      logic [63:0] oa [4];
      logic [5:0]  os [4];
      logic [63:0] ex [4];
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (c >= 3 && c < 7) begin
            if (ov[1] !== 1'b1 || ores[1] !== ex[c-3]) begin
               errors++;
               $display("FAIL back_to_back op%0d: valid=%b res=%h, expected valid=1 res=%h", c - 3, ov[1], ores[1], ex[c-3]);
            end
         end else if (ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle cycle%0d: valid=%b, expected valid=0", c, ov[1]);
         end
         if (c < 4) begin
            om[c] = 3'($urandom_range(0, 4));
            ow[c] = 1'($urandom_range(0, 1));
            oa[c] = {$urandom, $urandom};
            os[c] = 6'($urandom_range(0, 63));
            ex[c] = ref_shift(om[c], ow[c], oa[c], os[c], 1'b1);
            drive(1'b1, 1'b0, om[c], ow[c], oa[c], os[c]);
         end else begin
            drive(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 6'd0);
         end
      end
      for (int k = 0; k < 3; k++) last_res[k] = ref_shift(om[3], ow[3], oa[3], os[3], rot[k]);
   endtask

   task automatic test_flush();
      logic [2:0]  om [4];
      logic        ow [4];
      logic [63:0] oa [4];
      logic [5:0]  os [4];
      bit          ev;
      logic [63:0] er;
      int          due;
      for (int i = 0; i < 4; i++) begin
         om[i] = 3'($urandom_range(0, 4));
         ow[i] = 1'($urandom_range(0, 1));
         oa[i] = {$urandom, $urandom} | 64'h1;
         os[i] = 6'($urandom_range(1, 30));
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            ev = 1'b0;
            er = last_res[k];
            for (int i = 0; i < 4; i++) begin
               due = i + stg[k];
               // op 2 is issued with the flush; ops 0/1 die if still in flight at cycle 2
               if (i != 2 && !(i < 2 && due >= 3) && due == c) begin
                  ev = 1'b1;
                  er = ref_shift(om[i], ow[i], oa[i], os[i], rot[k]);
               end
            end
            checks++;
            if (ov[k] !== ev || ores[k] !== er) begin
               errors++;
               $display("FAIL flush inst%0d cycle%0d: valid=%b res=%h, expected valid=%b res=%h", k, c, ov[k], ores[k], ev, er);
            end
            last_res[k] = er;
         end
         if (c < 4) drive(1'b1, c == 2, om[c], ow[c], oa[c], os[c]);
         else       drive(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 6'd0);
      end
   endtask

   task automatic test_random();
      logic [2:0]  m;
      logic        w;
      logic [63:0] x;
      logic [5:0]  s;
      logic        f;
      logic        e;
      ent_t        ent;
      for (int k = 0; k < 3; k++) sb[k].delete();
      for (int c = 0; c < 305; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (sb[k].size() > 0 && sb[k][0].due == c) begin
               if (ov[k] !== 1'b1 || ores[k] !== sb[k][0].res) begin
                  errors++;
                  $display("FAIL random inst%0d cycle%0d: valid=%b res=%h, expected valid=1 res=%h", k, c, ov[k], ores[k], sb[k][0].res);
               end
               last_res[k] = sb[k][0].res;
               void'(sb[k].pop_front());
            end else if (ov[k] !== 1'b0 || ores[k] !== last_res[k]) begin
               errors++;
               $display("FAIL random_idle inst%0d cycle%0d: valid=%b res=%h, expected valid=0 res=%h", k, c, ov[k], ores[k], last_res[k]);
            end
         end
         if (c < 300) begin
            m = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            w = 1'($urandom_range(0, 1));
            x = {$urandom, $urandom};
            s = 6'($urandom_range(0, 63));
            f = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            if (f) begin
               for (int k = 0; k < 3; k++) sb[k].delete();
            end else if (e) begin
               for (int k = 0; k < 3; k++) begin
                  ent.due = c + stg[k];
                  ent.res = ref_shift(m, w, x, s, rot[k]);
                  sb[k].push_back(ent);
               end
            end
            drive(e, f, m, w, x, s);
         end else begin
            drive(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 6'd0);
         end
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      drive(1'b1, 1'b0, 3'd0, 1'b0, 64'h5, 6'd1);
      @(negedge clk);
      drive(1'b1, 1'b0, 3'd1, 1'b0, 64'hF0, 6'd4);
      @(posedge clk);
      #2;
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 6'd0);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || ores[k] !== 64'd0) begin
            errors++;
            $display("FAIL reset_midflight inst%0d: valid=%b res=%h, expected valid=0 res=0", k, ov[k], ores[k]);
         end
         sb[k].delete();
         last_res[k] = 64'd0;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ores[k] !== 64'd0) begin
               errors++;
               $display("FAIL reset_after inst%0d cycle%0d: valid=%b res=%h, expected valid=0 res=0", k, c, ov[k], ores[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined successor to the single-register River shifter.
- Performs SLL/SRL/SRA plus Zbb rotates ROL/ROR on XLEN-bit or 32-bit (RV64 "W") operands.
- Splits the barrel shift across a configurable number of register stages.
- Sits in the integer ALU path next to the adder and multiplier. Fixed latency, no back-pressure. Accepts one operation per cycle.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- STAGES, 2, number of pipeline register stages; legal values 1 to $clog2(XLEN).
- ROT_EN, 1, 1 enables ROL/ROR; 0 makes rotate modes behave as SLL/SRL.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ena  in  1  operation valid this cycle.
- i_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved.
- i_word  in  1  32-bit W variant; ignored (treated as 0) when XLEN=32.
- i_a1  in  XLEN  operand to shift.
- i_a2  in  $clog2(XLEN)  shift amount.
- i_flush  in  1  kill all in-flight operations.
- o_valid  out  1  o_res holds a completed result.
- o_res  out  XLEN  shifted result.

Behaviour:
- Reset: every stage valid bit and data register clears to 0 asynchronously; o_valid=0, o_res=0 while i_rst is high and on the first edge after release.
- Latency:
  - Op sampled with i_ena=1 at edge N appears with o_valid=1 at edge N+STAGES-1, registered output.
  - STAGES=1 means the result is visible the cycle after sampling.
  - Throughput is 1 op/cycle. Back-to-back ops keep order.
- Stage split: amount bits are partitioned from LSB up. Each stage handles ceil($clog2(XLEN)/STAGES) bits; the last stage takes the remainder.
  - Each stage registers the partial result, mode, word flag, remaining amount bits and valid.
- Amount masking: word mode uses i_a2[4:0] (bit 5 ignored). Full mode uses all bits.
- SRA: fills with i_a1[XLEN-1]. In word mode it fills with i_a1[31].
- Word mode:
  - Operate on i_a1[31:0] only; upper input bits are ignored.
  - Rotates wrap within 32 bits.
  - Final result = sign-extension of the 32-bit result bit 31 to XLEN, for all modes.
- Rotate: ROL by 0 and ROR by 0 return the operand unchanged. With ROT_EN=0, ROL acts as SLL and ROR as SRL.
- Reserved modes: produce o_res=0 with o_valid=1. The pipeline is not stalled.
- Flush:
  - i_flush=1 at an edge clears all stage valid bits at that edge.
  - o_valid=0 the following cycle. Data registers may hold stale values.
  - i_flush and i_ena in the same cycle: the flush wins and the new op is discarded.
- o_res is updated only when the last stage captures a valid op. It holds its value while o_valid=0.
- Reset asserted mid-operation: all in-flight ops are lost and no o_valid pulse follows.

Test Plan:
- XLEN=64, STAGES=2: SLL a1=0x1, a2=63 -> o_valid one edge after sample; o_res=0x8000_0000_0000_0000.
- SRA a1=0x8000_0000_0000_0000, a2=4 -> 0xF800_0000_0000_0000. SRL with the same inputs -> 0x0800_0000_0000_0000.
- Word SRA (i_word=1), a1=0xFFFF_FFFF_8000_0000, a2=36 (masked to 4) -> 0xFFFF_FFFF_F800_0000. Word SLL a1=0x1, a2=31 -> 0xFFFF_FFFF_8000_0000.
- ROR a1=0x1, a2=1 -> 0x8000_0000_0000_0000. Word ROL a1=0x8000_0001, a2=1 -> 0x3. With ROT_EN=0, ROR a1=0x1, a2=1 -> 0.
- Stream 4 back-to-back ops at STAGES=3 -> 4 consecutive o_valid pulses in order. Assert i_flush with the 3rd op -> ops 1-3 dropped, only op 4 (issued after the flush) emerges.
- Assert i_rst while 2 ops are in flight -> o_valid and o_res read 0 immediately (asynchronously). No o_valid pulse appears after reset is released.
